// File: rtl/intr_injector_pkg.sv
// Shared types and helpers for the interrupt injector: channel FSM states and
// acknowledge-word address arithmetic.
package intr_inj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_ASSERT,
    ST_REARM,
    ST_DONE
  } ch_state_e;

  localparam int unsigned ACK_STRIDE = 4;

  function automatic logic [31:0] ack_addr(input logic [31:0] base, input int unsigned ch);
    return base + 32'(ACK_STRIDE * ch);
  endfunction

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_injector_if.sv
// CPU observation, configuration and interrupt-line bundle for intr_injector.
// master = bench/CPU side, slave = injector side.
interface intr_injector_if #(
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DLY_W    = 8
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [31:0]         macroscopic_pc;
  logic [31:0]         m_int_addr;
  logic [3:0]          m_int_byteen;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [31:0]         cfg_target_pc;
  logic [CNT_W-1:0]    cfg_count;
  logic [DLY_W-1:0]    cfg_delay;
  logic [CHANNELS-1:0] interrupt;
  logic [CHANNELS-1:0] done;
  logic                busy;
  logic [CHANNELS-1:0] timeout_err;

  modport master (
    output macroscopic_pc, m_int_addr, m_int_byteen,
    output cfg_we, cfg_ch, cfg_target_pc, cfg_count, cfg_delay,
    input  interrupt, done, busy, timeout_err
  );

  modport slave (
    input  macroscopic_pc, m_int_addr, m_int_byteen,
    input  cfg_we, cfg_ch, cfg_target_pc, cfg_count, cfg_delay,
    output interrupt, done, busy, timeout_err
  );
endinterface

// File: rtl/intr_injector_channel.sv
// One interrupt channel: PC-match trigger, optional delay, ack-held line, re-arm.
// Optional ack timeout built only when INTR_INJ_TIMEOUT_EN is defined.
module intr_inj_channel
  import intr_inj_pkg::*;
#(
  parameter int unsigned CH_IDX   = 0,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_we,
  input  logic [31:0]      i_cfg_target,
  input  logic [CNT_W-1:0] i_cfg_count,
  input  logic [DLY_W-1:0] i_cfg_delay,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_st_addr,
  input  logic [3:0]       i_st_byteen,
  output logic             o_interrupt,
  output logic             o_done,
  output logic             o_active,
  output logic             o_timeout_err
);
  localparam logic [31:0] ACK_ADDR = ack_addr(ACK_BASE, CH_IDX);

  ch_state_e        r_state, w_state_nxt;
  logic [29:0]      r_target;
  logic [CNT_W-1:0] r_remaining;
  logic [DLY_W-1:0] r_delay;
  logic [DLY_W-1:0] r_dly_cnt;
  logic             r_interrupt;
  logic             r_done;
  logic             w_match;
  logic             w_ack;
  logic             w_timeout;
  logic             w_unused;

  assign w_match = (i_pc[31:2] == r_target);
  assign w_ack   = (|i_st_byteen) && (i_st_addr[31:2] == ACK_ADDR[31:2]);

`ifdef INTR_INJ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_err;

  assign w_timeout = (r_state == ST_ASSERT) && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else if (i_cfg_we) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else if (r_state == ST_ASSERT && !w_ack) begin
      if (w_timeout) begin
        r_to_cnt <= '0;
        r_to_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign o_timeout_err = r_to_err;
  assign w_unused = ^{1'b0, i_pc[1:0], i_st_addr[1:0], i_cfg_target[1:0], ACK_ADDR[1:0]};
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
  assign w_unused = ^{1'b0, i_pc[1:0], i_st_addr[1:0], i_cfg_target[1:0], ACK_ADDR[1:0],
                      32'(TIMEOUT)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_IDLE;
      ST_ARMED:  if (w_match) w_state_nxt = (r_delay == '0) ? ST_ASSERT : ST_DELAY;
      ST_DELAY:  if (r_dly_cnt <= DLY_W'(1)) w_state_nxt = ST_ASSERT;
      ST_ASSERT: if (w_ack || w_timeout)
                   w_state_nxt = (r_remaining == '0) ? ST_DONE : ST_REARM;
      ST_REARM:  if (!w_match) w_state_nxt = ST_ARMED;
      ST_DONE:   w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // Configuration overrides whatever the channel was doing this cycle.
    if (i_cfg_we) w_state_nxt = (i_cfg_count == '0) ? ST_IDLE : ST_ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target    <= '0;
      r_remaining <= '0;
      r_delay     <= '0;
      r_dly_cnt   <= '0;
    end else if (i_cfg_we) begin
      r_target    <= i_cfg_target[31:2];
      r_remaining <= i_cfg_count;
      r_delay     <= i_cfg_delay;
      r_dly_cnt   <= '0;
    end else if (r_state == ST_ARMED && w_match) begin
      if (r_remaining != '0) r_remaining <= r_remaining - CNT_W'(1);
      r_dly_cnt <= r_delay;
    end else if (r_state == ST_DELAY && r_dly_cnt != '0) begin
      r_dly_cnt <= r_dly_cnt - DLY_W'(1);
    end
  end

  // Lines follow the state one edge later, but a config write drops them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_interrupt <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_interrupt <= !i_cfg_we && (r_state == ST_ASSERT);
      r_done      <= !i_cfg_we && (r_state == ST_DONE);
    end
  end

  assign o_interrupt = r_interrupt;
  assign o_done      = r_done;
  assign o_active    = (r_state == ST_ARMED) || (r_state == ST_DELAY) ||
                       (r_state == ST_ASSERT) || (r_state == ST_REARM);

endmodule

// File: rtl/intr_injector.sv
// Multi-channel PC-triggered interrupt generator for the MIPS benches.
// Optional per-channel ack timeout: define INTR_INJ_TIMEOUT_EN.
module intr_injector
  import intr_inj_pkg::*;
#(
  parameter int unsigned CHANNELS = 6,
  parameter logic [31:0] ACK_BASE = 32'h0000_7f20,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic            clk,
  input  logic            reset,
  intr_injector_if.slave  bus
);
  localparam int unsigned CH_W = ch_width(CHANNELS);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [CHANNELS-1:0] w_cfg_we;
  logic [CHANNELS-1:0] w_interrupt;
  logic [CHANNELS-1:0] w_done;
  logic [CHANNELS-1:0] w_active;
  logic [CHANNELS-1:0] w_timeout_err;

  // Assert asynchronously, release two edges after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign w_cfg_we[gi] = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

    intr_inj_channel #(
      .CH_IDX   (gi),
      .ACK_BASE (ACK_BASE),
      .CNT_W    (CNT_W),
      .DLY_W    (DLY_W),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk           (clk),
      .rst_n         (w_rst_n),
      .i_cfg_we      (w_cfg_we[gi]),
      .i_cfg_target  (bus.cfg_target_pc),
      .i_cfg_count   (bus.cfg_count),
      .i_cfg_delay   (bus.cfg_delay),
      .i_pc          (bus.macroscopic_pc),
      .i_st_addr     (bus.m_int_addr),
      .i_st_byteen   (bus.m_int_byteen),
      .o_interrupt   (w_interrupt[gi]),
      .o_done        (w_done[gi]),
      .o_active      (w_active[gi]),
      .o_timeout_err (w_timeout_err[gi])
    );
  end

  assign bus.interrupt   = w_interrupt;
  assign bus.done        = w_done;
  assign bus.busy        = |w_active;
  assign bus.timeout_err = w_timeout_err;

endmodule

// File: tb/tb_intr_injector.sv
// Directed bench for intr_injector; define INTR_INJ_TIMEOUT_EN to exercise the
// 16-cycle ack timeout instead of the indefinite wait.
module tb_intr_injector;
  localparam int unsigned NCH = 6;
`ifdef INTR_INJ_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  intr_injector_if #(.CHANNELS(NCH), .CNT_W(8), .DLY_W(8)) bus ();

  intr_injector #(
    .CHANNELS (NCH),
    .ACK_BASE (32'h0000_7f20),
    .CNT_W    (8),
    .DLY_W    (8),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int unsigned ch, input logic [31:0] tgt,
                     input logic [7:0] cnt, input logic [7:0] dly);
    bus.cfg_we        = 1'b1;
    bus.cfg_ch        = 3'(ch);
    bus.cfg_target_pc = tgt;
    bus.cfg_count     = cnt;
    bus.cfg_delay     = dly;
    tick();
    bus.cfg_we        = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] be);
    bus.m_int_addr   = addr;
    bus.m_int_byteen = be;
    tick();
    bus.m_int_byteen = 4'h0;
  endtask

  initial begin
    reset              = 1'b0;
    bus.macroscopic_pc = 32'h1000;
    bus.m_int_addr     = 32'h0;
    bus.m_int_byteen   = 4'h0;
    bus.cfg_we         = 1'b0;
    bus.cfg_ch         = '0;
    bus.cfg_target_pc  = 32'h0;
    bus.cfg_count      = 8'h0;
    bus.cfg_delay      = 8'h0;
    tick(3);
    chk("rst_int",  32'(bus.interrupt), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_terr", 32'(bus.timeout_err), 32'h0);
    reset = 1'b1;
    tick(3);

    // Ch0: count 1, delay 0, single fire then DONE
    cfg(0, 32'h3010, 8'd1, 8'd0);
    chk("t1_busy_armed", 32'(bus.busy), 32'h1);
    bus.macroscopic_pc = 32'h3010;
    tick();
    chk("t1_int_match_edge", 32'(bus.interrupt), 32'h0);
    tick();
    chk("t1_int_high", 32'(bus.interrupt), 32'h01);
    tick(3);
    chk("t1_int_held", 32'(bus.interrupt), 32'h01);
    store(32'h7f20, 4'hf);
    chk("t1_int_ack_edge", 32'(bus.interrupt), 32'h01);
    chk("t1_done_ack_edge", 32'(bus.done), 32'h0);
    tick();
    chk("t1_int_low", 32'(bus.interrupt), 32'h0);
    chk("t1_done", 32'(bus.done), 32'h01);
    chk("t1_busy_idle", 32'(bus.busy), 32'h0);

    // Ch2: count 2, delay 3, no re-fire while PC parked on target
    cfg(2, 32'h3020, 8'd2, 8'd3);
    bus.macroscopic_pc = 32'h3020;
    tick();
    chk("t2_int_k", 32'(bus.interrupt), 32'h0);
    tick(3);
    chk("t2_int_k3", 32'(bus.interrupt), 32'h0);
    tick();
    chk("t2_int_k4", 32'(bus.interrupt), 32'h04);
    store(32'h7f28, 4'hf);
    chk("t2_int_ack_edge", 32'(bus.interrupt), 32'h04);
    tick();
    chk("t2_int_low", 32'(bus.interrupt), 32'h0);
    chk("t2_done_not_yet", 32'(bus.done), 32'h01);
    tick(8);
    chk("t2_no_refire", 32'(bus.interrupt), 32'h0);
    chk("t2_busy_rearm", 32'(bus.busy), 32'h1);
    bus.macroscopic_pc = 32'h3024;
    tick();
    bus.macroscopic_pc = 32'h3020;
    tick();
    tick(3);
    chk("t2_fire2_k3", 32'(bus.interrupt), 32'h0);
    tick();
    chk("t2_fire2_k4", 32'(bus.interrupt), 32'h04);
    store(32'h7f28, 4'hf);
    tick();
    chk("t2_int_low2", 32'(bus.interrupt), 32'h0);
    chk("t2_done", 32'(bus.done), 32'h05);
    chk("t2_busy_idle", 32'(bus.busy), 32'h0);

    // Ch0 + ch1 concurrently, independent acks
    cfg(0, 32'h3100, 8'd1, 8'd0);
    cfg(1, 32'h3100, 8'd1, 8'd0);
    chk("t3_done_cleared", 32'(bus.done), 32'h04);
    bus.macroscopic_pc = 32'h3100;
    tick(2);
    chk("t3_both_high", 32'(bus.interrupt), 32'h03);
    store(32'h7f24, 4'h0);
    tick();
    chk("t3_no_byteen", 32'(bus.interrupt), 32'h03);
    store(32'h7f24, 4'hf);
    tick();
    chk("t3_ch1_cleared", 32'(bus.interrupt), 32'h01);
    chk("t3_ch1_done", 32'(bus.done), 32'h06);
    store(32'h7f23, 4'h1);
    tick();
    chk("t3_ch0_cleared", 32'(bus.interrupt), 32'h0);
    chk("t3_ch0_done", 32'(bus.done), 32'h07);
    store(32'h7f28, 4'hf);
    tick();
    chk("t3_stray_ack_int", 32'(bus.interrupt), 32'h0);
    chk("t3_stray_ack_done", 32'(bus.done), 32'h07);

    // Ch3 reconfigured with count 0 while asserted
    bus.macroscopic_pc = 32'h3200;
    cfg(3, 32'h3200, 8'd3, 8'd1);
    tick();
    chk("t4_delay", 32'(bus.interrupt), 32'h0);
    tick(2);
    chk("t4_int_high", 32'(bus.interrupt), 32'h08);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    cfg(3, 32'h0, 8'd0, 8'd0);
    chk("t4_int_drop", 32'(bus.interrupt), 32'h0);
    chk("t4_busy_drop", 32'(bus.busy), 32'h0);
    chk("t4_done", 32'(bus.done), 32'h07);
    tick(3);
    chk("t4_stays_idle", 32'(bus.interrupt), 32'h0);

    // Async reset between edges while ch4/ch5 asserted
    cfg(4, 32'h3300, 8'd2, 8'd0);
    cfg(5, 32'h3300, 8'd2, 8'd0);
    bus.macroscopic_pc = 32'h3300;
    tick(2);
    chk("t5_both_high", 32'(bus.interrupt), 32'h30);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_rst_int", 32'(bus.interrupt), 32'h0);
    chk("t5_rst_done", 32'(bus.done), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(12);
    chk("t5_no_fire_int", 32'(bus.interrupt), 32'h0);
    chk("t5_no_fire_busy", 32'(bus.busy), 32'h0);

    // Unacked assert on ch1: timeout or indefinite hold
    cfg(1, 32'h3500, 8'd1, 8'd0);
    bus.macroscopic_pc = 32'h3500;
    tick(2);
    chk("t6_int_high", 32'(bus.interrupt), 32'h02);
`ifdef INTR_INJ_TIMEOUT_EN
    tick(15);
    chk("t6_int_last", 32'(bus.interrupt), 32'h02);
    chk("t6_terr_set", 32'(bus.timeout_err), 32'h02);
    tick();
    chk("t6_int_drop", 32'(bus.interrupt), 32'h0);
    chk("t6_done", 32'(bus.done), 32'h02);
    tick(5);
    chk("t6_terr_sticky", 32'(bus.timeout_err), 32'h02);
    cfg(1, 32'h0, 8'd0, 8'd0);
    chk("t6_terr_cfg_clr", 32'(bus.timeout_err), 32'h0);
`else
    tick(40);
    chk("t6_int_hold", 32'(bus.interrupt), 32'h02);
    chk("t6_terr_zero", 32'(bus.timeout_err), 32'h0);
    store(32'h7f24, 4'hc);
    tick();
    chk("t6_int_drop", 32'(bus.interrupt), 32'h0);
    chk("t6_done", 32'(bus.done), 32'h02);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
